// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection, forwarding select and stall sequencing for the 5-stage core
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rs1,
  input  logic [REG_ADDR_W-1:0] idex_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  exmem_regwrite,
  input  logic                  memwb_regwrite,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_src,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  freeze,
  output logic [CNT_W-1:0]      stall_count,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01
  } state_t;

  // Bubbles remaining after the first one, which is issued from RUN.
  localparam logic [1:0] LU_INIT  = 2'(LOAD_STALL - 1);
  localparam bit         MULTI_LU = (LOAD_STALL > 1);

  state_t     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       mem_wait;
  logic       load_use;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = idex_memread && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  assign state    = state_q;

  // State and bubble counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Next state: a memory wait freezes everything, a branch aborts any stall
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (mem_wait) begin
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;
    end else if (branch_taken) begin
      state_d  = RUN;
      lu_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (load_use && MULTI_LU) begin
        state_d  = LU_STALL;
        lu_cnt_d = LU_INIT;
      end
    end else begin
      lu_cnt_d = lu_cnt_q - 2'd1;
      if (lu_cnt_q <= 2'd1) state_d = RUN;
    end
  end

  // Pipeline control decode in priority order; reset forces a safe flushed pipe
  always_comb begin
    pc_src      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_wait) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (branch_taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state_q == RUN && load_use) || state_q == LU_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Operand forwarding: the younger EX/MEM result beats MEM/WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (exmem_regwrite && exmem_rd != '0 && exmem_rd == idex_rs1)      fwd_a = 2'b10;
      else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_rs1) fwd_a = 2'b01;
      if (exmem_regwrite && exmem_rd != '0 && exmem_rd == idex_rs2)      fwd_b = 2'b10;
      else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_rs2) fwd_b = 2'b01;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_memread, exmem_regwrite, memwb_regwrite, branch_taken, dmem_req, dmem_ready;

  // dut_a: LOAD_STALL = 2, CNT_W = 4
  logic [1:0]  a_fwd_a, a_fwd_b, a_state;
  logic        a_pc_src, a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_freeze;
  logic [3:0]  a_sc;
  // dut_b: LOAD_STALL = 3, CNT_W = 32
  logic [1:0]  b_fwd_a, b_fwd_b, b_state;
  logic        b_pc_src, b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_freeze;
  logic [31:0] b_sc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_regwrite(memwb_regwrite), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .pc_src(a_pc_src),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .idex_bubble(a_idex_bubble), .freeze(a_freeze), .stall_count(a_sc), .state(a_state)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_regwrite(memwb_regwrite), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .pc_src(b_pc_src),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .idex_bubble(b_idex_bubble), .freeze(b_freeze), .stall_count(b_sc), .state(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rs1 = 5'd0; idex_rs2 = 5'd0; idex_rd = 5'd0;
    exmem_rd = 5'd0; memwb_rd = 5'd0; idex_memread = 1'b0; exmem_regwrite = 1'b0;
    memwb_regwrite = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_hazard();
    idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs2 = 5'd3;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    exmem_regwrite = 1'b1; exmem_rd = 5'd7; idex_rs1 = 5'd7;
    #3;
    checks++; if (a_state !== 2'b00) begin errors++; $display("FAIL rst_state got=%b exp=00", a_state); end
    checks++; if (b_sc !== 32'd0) begin errors++; $display("FAIL rst_stall_count got=%0d exp=0", b_sc); end
    checks++; if ({a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pc_src, a_freeze} !== 6'b001100) begin
      errors++; $display("FAIL rst_controls got=%b exp=001100", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pc_src, a_freeze}); end
    checks++; if (a_fwd_a !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got=%b exp=00", a_fwd_a); end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if ({a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble} !== 4'b1100) begin
      errors++; $display("FAIL rst_release_controls got=%b exp=1100", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble}); end
    checks++; if (a_sc !== 4'd0) begin errors++; $display("FAIL rst_release_count got=%0d exp=0", a_sc); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    exmem_rd = 5'd5; memwb_rd = 5'd5; idex_rs1 = 5'd5; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
    #1;
    checks++; if (a_fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_both got=%b exp=10", a_fwd_a); end
    exmem_rd = 5'd0;
    #1;
    checks++; if (a_fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_exmem_x0 got=%b exp=01", a_fwd_a); end
    exmem_rd = 5'd9; idex_rs2 = 5'd9; memwb_regwrite = 1'b0;
    #1;
    checks++; if ({a_fwd_a, a_fwd_b} !== 4'b0010) begin errors++; $display("FAIL fwd_split got=%b exp=0010", {a_fwd_a, a_fwd_b}); end
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b1; memwb_rd = 5'd9;
    #1;
    checks++; if ({a_fwd_a, a_fwd_b} !== 4'b0001) begin errors++; $display("FAIL fwd_memwb_b got=%b exp=0001", {a_fwd_a, a_fwd_b}); end
    clear_inputs();
    exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
    #1;
    checks++; if ({b_fwd_a, b_fwd_b} !== 4'b0000) begin errors++; $display("FAIL fwd_all_zero got=%b exp=0000", {b_fwd_a, b_fwd_b}); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_hazard();
    #1;
    checks++; if ({a_pc_write, a_ifid_write, a_idex_bubble} !== 3'b001) begin
      errors++; $display("FAIL lu_c1 got=%b exp=001", {a_pc_write, a_ifid_write, a_idex_bubble}); end
    tick();
    clear_inputs();
    #1;
    checks++; if ({a_state, a_pc_write, a_idex_bubble} !== 4'b0101) begin
      errors++; $display("FAIL lu_c2 got=%b exp=0101", {a_state, a_pc_write, a_idex_bubble}); end
    tick();
    checks++; if ({a_state, a_pc_write, a_idex_bubble} !== 4'b0010) begin
      errors++; $display("FAIL lu_done got=%b exp=0010", {a_state, a_pc_write, a_idex_bubble}); end
    checks++; if (a_sc !== 4'd2) begin errors++; $display("FAIL lu_count got=%0d exp=2", a_sc); end
  endtask

  task automatic test_branch_mid_stall();
    apply_reset();
    set_hazard();
    tick();
    clear_inputs();
    branch_taken = 1'b1;
    #1;
    checks++; if ({b_pc_src, b_ifid_flush, b_pc_write, b_idex_bubble} !== 4'b1111) begin
      errors++; $display("FAIL br_mid_controls got=%b exp=1111", {b_pc_src, b_ifid_flush, b_pc_write, b_idex_bubble}); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (b_state !== 2'b00) begin errors++; $display("FAIL br_mid_state got=%b exp=00", b_state); end
    checks++; if (b_sc !== 32'd1) begin errors++; $display("FAIL br_mid_count got=%0d exp=1", b_sc); end
    checks++; if (b_pc_write !== 1'b1) begin errors++; $display("FAIL br_mid_resume got=%b exp=1", b_pc_write); end
  endtask

  task automatic test_branch_with_hazard();
    apply_reset();
    set_hazard();
    branch_taken = 1'b1;
    #1;
    checks++; if ({a_pc_src, a_pc_write} !== 2'b11) begin errors++; $display("FAIL br_hz_controls got=%b exp=11", {a_pc_src, a_pc_write}); end
    tick();
    clear_inputs();
    #1;
    checks++; if ({b_state, b_sc[3:0]} !== 6'b000000) begin errors++; $display("FAIL br_hz_after got=%b exp=000000", {b_state, b_sc[3:0]}); end
  endtask

  task automatic test_mem_wait();
    int low;
    apply_reset();
    low = 0;
    set_hazard();
    #1;
    if (a_pc_write === 1'b0) low++;
    tick();
    clear_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({a_freeze, a_state, a_idex_bubble} !== 4'b1010) begin
        errors++; $display("FAIL mw_freeze_%0d got=%b exp=1010", i, {a_freeze, a_state, a_idex_bubble}); end
      if (a_pc_write === 1'b0) low++;
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if ({a_freeze, a_state, a_pc_write} !== 4'b0010) begin
      errors++; $display("FAIL mw_last_bubble got=%b exp=0010", {a_freeze, a_state, a_pc_write}); end
    if (a_pc_write === 1'b0) low++;
    tick();
    checks++; if (low != 6) begin errors++; $display("FAIL mw_low_cycles got=%0d exp=6", low); end
    checks++; if ({a_state, a_pc_write, a_sc} !== 7'b0010110) begin
      errors++; $display("FAIL mw_done got=%b exp=0010110", {a_state, a_pc_write, a_sc}); end
    clear_inputs();
  endtask

  task automatic test_freeze_vs_branch();
    apply_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    #1;
    checks++; if ({a_freeze, a_pc_src, a_ifid_flush, a_idex_bubble, a_pc_write} !== 5'b10000) begin
      errors++; $display("FAIL fz_br got=%b exp=10000", {a_freeze, a_pc_src, a_ifid_flush, a_idex_bubble, a_pc_write}); end
    tick();
    dmem_ready = 1'b1;
    #1;
    checks++; if ({a_freeze, a_pc_src, a_sc} !== 6'b010001) begin
      errors++; $display("FAIL fz_br_release got=%b exp=010001", {a_freeze, a_pc_src, a_sc}); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_hazard();
    tick();
    clear_inputs();
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({b_state, b_sc[3:0]} !== 6'b000000) begin errors++; $display("FAIL rst_mid got=%b exp=000000", {b_state, b_sc[3:0]}); end
    checks++; if (b_ifid_flush !== 1'b1) begin errors++; $display("FAIL rst_mid_flush got=%b exp=1", b_ifid_flush); end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if ({b_state, b_pc_write, b_idex_bubble} !== 4'b0010) begin
      errors++; $display("FAIL rst_mid_release got=%b exp=0010", {b_state, b_pc_write, b_idex_bubble}); end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_hazard();
    repeat (20) tick();
    checks++; if (a_sc !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", a_sc); end
    checks++; if (b_sc !== 32'd20) begin errors++; $display("FAIL sat_cnt32 got=%0d exp=20", b_sc); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_mid_stall();
    test_branch_with_hazard();
    test_mem_wait();
    test_freeze_vs_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
